key_event_arbiter: RTL and testbench

Collects single-cycle debounced key pulses from up to N_KEYS button channels, arbitrates between them round-robin, and delivers them one at a time as coded events through a small FIFO with a valid/ready handshake. It sits between the per-button debounce stages and the LED display mode/state controller. A burst of simultaneous presses is serialised without loss. A press that cannot be recorded is counted as an overflow and is never silently merged.

---
 rtl/key_evt_pkg.sv | 37 +++
 rtl/key_evt_fifo.sv | 64 ++++++
 rtl/key_event_arbiter.sv | 117 +++++++++++
 tb/tb_key_event_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared constants, types and the round-robin select helper for key_event_arbiter.
package key_evt_pkg;

  localparam int unsigned DEF_N_KEYS     = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned MAX_KEYS       = 16;
  localparam int unsigned IDX_W          = 4;

  localparam int unsigned          DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_sel_t;

  // First set request at or above ptr, wrapping modulo n.
  function automatic rr_sel_t rr_select(input logic [MAX_KEYS-1:0] req,
                                        input logic [IDX_W-1:0]    ptr,
                                        input int unsigned         n);
    rr_sel_t     r;
    int unsigned j;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned k = 0; k < MAX_KEYS; k++) begin
      if (k < n && !r.found) begin
        j = (32'(ptr) + k) % n;
        if (req[j]) begin
          r.found = 1'b1;
          r.idx   = IDX_W'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Shift-register event FIFO; head is always entry 0 and empty entries read as zero.
module key_evt_fifo
  import key_evt_pkg::*;
#(
  parameter  int unsigned CODE_W     = 2,
  parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              button1,
  input  logic              push,
  input  logic              pop,
  input  logic [CODE_W-1:0] din,
  output logic [CODE_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [CODE_W-1:0] mem_d [FIFO_DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  wr_idx;
  logic              do_push, do_pop;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[0];
  assign count = count_q;

  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    // Shifting on pop keeps the head registered and clears vacated slots to zero.
    for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) begin
      mem_d[i] = do_pop ? mem_q[i+1] : mem_q[i];
    end
    mem_d[FIFO_DEPTH-1] = do_pop ? '0 : mem_q[FIFO_DEPTH-1];
    wr_idx = do_pop ? (count_q - CNT_W'(1)) : count_q;
    if (do_push) begin
      mem_d[wr_idx[CNT_W-2:0]] = din;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge button1) begin
    if (button1) begin
      count_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Round-robin key pulse arbiter feeding an event FIFO with valid/ready output.
// Optional per-drop counter output enabled by defining KEY_EVT_DROP_CNT_EN.
module key_event_arbiter
  import key_evt_pkg::*;
#(
  parameter  int unsigned N_KEYS     = DEF_N_KEYS,
  parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned CODE_W     = $clog2(N_KEYS),
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              button1,
  input  logic [N_KEYS-1:0] key_pulse,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  input  logic              evt_ready,
  output logic [N_KEYS-1:0] pending,
  output logic              overflow,
  output logic [CNT_W-1:0]  evt_count
`ifdef KEY_EVT_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  logic [N_KEYS-1:0]   pending_q, pending_d;
  logic [CODE_W-1:0]   ptr_q, ptr_d;
  logic                overflow_q, overflow_d;
  logic [N_KEYS-1:0]   grant_oh;
  logic [N_KEYS-1:0]   drop;
  logic [MAX_KEYS-1:0] req_ext;
  logic [IDX_W-1:0]    ptr_ext;
  rr_sel_t             sel;
  logic                push, pop;
  logic [CODE_W-1:0]   push_code;
  logic                fifo_full, fifo_empty;

  assign evt_valid = ~fifo_empty;
  assign pop       = evt_valid & evt_ready;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

  always_comb begin
    req_ext               = '0;
    req_ext[N_KEYS-1:0]   = pending_q;
    ptr_ext               = '0;
    ptr_ext[CODE_W-1:0]   = ptr_q;
    sel                   = rr_select(req_ext, ptr_ext, N_KEYS);
    push                  = sel.found & ~fifo_full;
    push_code             = sel.idx[CODE_W-1:0];
    grant_oh              = '0;
    if (push) begin
      grant_oh[push_code] = 1'b1;
    end
    // A press landing on the cycle its key is granted re-arms the flag rather than dropping.
    drop       = key_pulse & pending_q & ~grant_oh;
    pending_d  = (pending_q & ~grant_oh) | key_pulse;
    overflow_d = overflow_q | (|drop);
    ptr_d      = ptr_q;
    if (push) begin
      ptr_d = (32'(push_code) == N_KEYS - 1) ? '0 : (push_code + CODE_W'(1));
    end
  end

  always_ff @(posedge clk or posedge button1) begin
    if (button1) begin
      pending_q  <= '0;
      ptr_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      ptr_q      <= ptr_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef KEY_EVT_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_W:0]   drop_sum;
  logic [4:0]            n_drop;

  assign drop_cnt = drop_cnt_q;

  always_comb begin
    n_drop = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      n_drop = n_drop + 5'(drop[i]);
    end
    drop_sum   = {1'b0, drop_cnt_q} + (DROP_CNT_W + 1)'(n_drop);
    drop_cnt_d = (drop_sum > {1'b0, DROP_CNT_MAX}) ? DROP_CNT_MAX : drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge button1) begin
    if (button1) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

  key_evt_fifo #(
    .CODE_W     (CODE_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .button1 (button1),
    .push    (push),
    .pop     (pop),
    .din     (push_code),
    .dout    (evt_code),
    .count   (evt_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed self-checking bench for key_event_arbiter (N_KEYS=4, FIFO_DEPTH=4).
module tb_key_event_arbiter;

  logic       clk = 1'b0;
  logic       button1;
  logic [3:0] key_pulse;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic [3:0] pending;
  logic       overflow;
  logic [2:0] evt_count;
`ifdef KEY_EVT_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  key_event_arbiter #(
    .N_KEYS     (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .button1   (button1),
    .key_pulse (key_pulse),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .pending   (pending),
    .overflow  (overflow),
    .evt_count (evt_count)
`ifdef KEY_EVT_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    key_pulse = '0;
    evt_ready = 1'b0;
    button1   = 1'b1;
    #2;
    button1   = 1'b0;
  endtask

  task automatic test_reset();
    button1   = 1'b0;
    key_pulse = '0;
    evt_ready = 1'b0;
    #1;
    button1 = 1'b1;
    #2;
    n_checks++;
    if ({evt_valid, evt_code, pending, overflow, evt_count} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b code=%0d pending=%b ovf=%b count=%0d expected all zero",
               evt_valid, evt_code, pending, overflow, evt_count);
    end
`ifdef KEY_EVT_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt);
    end
`endif
    tick();
    button1 = 1'b0;
  endtask

  task automatic test_single_press();
    do_reset();
    evt_ready = 1'b1;
    key_pulse = 4'b0100;
    tick();
    key_pulse = '0;
    n_checks++;
    if (pending !== 4'b0100 || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pending: got pending=%b valid=%b expected 0100/0", pending, evt_valid);
    end
    tick();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'd2) begin
      n_fail++;
      $display("FAIL single_event: got valid=%b code=%0d expected 1/2", evt_valid, evt_code);
    end
    tick();
    n_checks++;
    if (evt_valid !== 1'b0 || evt_code !== 2'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: got valid=%b code=%0d ovf=%b expected 0/0/0", evt_valid, evt_code, overflow);
    end
  endtask

  task automatic test_burst();
    logic [3:0] exp_pend;
    do_reset();
    evt_ready = 1'b1;
    key_pulse = 4'b1111;
    tick();
    key_pulse = '0;
    n_checks++;
    if (pending !== 4'b1111) begin
      n_fail++;
      $display("FAIL burst_pending: got %b expected 1111", pending);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pend = 4'b1111 << (i + 1);
      n_checks++;
      if (evt_valid !== 1'b1 || evt_code !== 2'(i) || pending !== exp_pend) begin
        n_fail++;
        $display("FAIL burst_seq%0d: got valid=%b code=%0d pending=%b expected 1/%0d/%b",
                 i, evt_valid, evt_code, pending, i, exp_pend);
      end
    end
    tick();
    n_checks++;
    if (evt_valid !== 1'b0 || evt_count !== 3'd0) begin
      n_fail++;
      $display("FAIL burst_drain: got valid=%b count=%0d expected 0/0", evt_valid, evt_count);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    evt_ready = 1'b1;
    key_pulse = 4'b0010;
    tick();
    key_pulse = '0;
    tick();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'd1) begin
      n_fail++;
      $display("FAIL rr_first: got valid=%b code=%0d expected 1/1", evt_valid, evt_code);
    end
    key_pulse = 4'b0101;
    tick();
    key_pulse = '0;
    n_checks++;
    if (evt_valid !== 1'b0 || pending !== 4'b0101) begin
      n_fail++;
      $display("FAIL rr_pending: got valid=%b pending=%b expected 0/0101", evt_valid, pending);
    end
    tick();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'd2) begin
      n_fail++;
      $display("FAIL rr_order_a: got valid=%b code=%0d expected 1/2", evt_valid, evt_code);
    end
    tick();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'd0) begin
      n_fail++;
      $display("FAIL rr_order_b: got valid=%b code=%0d expected 1/0", evt_valid, evt_code);
    end
    tick();
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drain: got valid=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_backpressure_drop();
    logic [1:0] exp_codes [4];
    exp_codes[0] = 2'd1;
    exp_codes[1] = 2'd2;
    exp_codes[2] = 2'd3;
    exp_codes[3] = 2'd0;
    do_reset();
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_pulse = 4'b0001 << i;
      tick();
    end
    key_pulse = '0;
    tick();
    n_checks++;
    if (evt_count !== 3'd4 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_full: got count=%0d pending=%b expected 4/0000", evt_count, pending);
    end
    key_pulse = 4'b0001;
    tick();
    n_checks++;
    if (evt_count !== 3'd4 || pending !== 4'b0001 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_held: got count=%0d pending=%b ovf=%b expected 4/0001/0", evt_count, pending, overflow);
    end
    tick();
    key_pulse = '0;
    n_checks++;
    if (overflow !== 1'b1 || pending !== 4'b0001 || evt_count !== 3'd4) begin
      n_fail++;
      $display("FAIL bp_drop: got ovf=%b pending=%b count=%0d expected 1/0001/4", overflow, pending, evt_count);
    end
`ifdef KEY_EVT_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL bp_drop_cnt: got %0d expected 1", drop_cnt);
    end
`endif
    n_checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_head: got valid=%b code=%0d expected 1/0", evt_valid, evt_code);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (evt_valid !== 1'b1 || evt_code !== exp_codes[i]) begin
        n_fail++;
        $display("FAIL bp_release%0d: got valid=%b code=%0d expected 1/%0d", i, evt_valid, evt_code, exp_codes[i]);
      end
    end
    tick();
    n_checks++;
    if (evt_valid !== 1'b0 || evt_count !== 3'd0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain: got valid=%b count=%0d ovf=%b expected 0/0/1", evt_valid, evt_count, overflow);
    end
  endtask

  task automatic test_collision();
    do_reset();
    evt_ready = 1'b1;
    key_pulse = 4'b1000;
    tick();
    n_checks++;
    if (pending !== 4'b1000) begin
      n_fail++;
      $display("FAIL coll_pending: got %b expected 1000", pending);
    end
    tick();
    key_pulse = '0;
    n_checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'd3 || pending !== 4'b1000 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_first: got valid=%b code=%0d pending=%b ovf=%b expected 1/3/1000/0",
               evt_valid, evt_code, pending, overflow);
    end
    tick();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'd3 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL coll_second: got valid=%b code=%0d pending=%b expected 1/3/0000", evt_valid, evt_code, pending);
    end
    tick();
    n_checks++;
    if (evt_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_end: got valid=%b ovf=%b expected 0/0", evt_valid, overflow);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    evt_ready = 1'b0;
    key_pulse = 4'b0001;
    tick();
    key_pulse = 4'b0100;
    tick();
    key_pulse = 4'b1000;
    tick();
    key_pulse = 4'b0010;
    tick();
    key_pulse = '0;
    n_checks++;
    if (evt_count !== 3'd3 || pending !== 4'b0010) begin
      n_fail++;
      $display("FAIL mid_setup: got count=%0d pending=%b expected 3/0010", evt_count, pending);
    end
    #2;
    button1 = 1'b1;
    #1;
    n_checks++;
    if ({evt_valid, evt_code, pending, overflow, evt_count} !== 11'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b code=%0d pending=%b ovf=%b count=%0d expected all zero",
               evt_valid, evt_code, pending, overflow, evt_count);
    end
    tick();
    button1   = 1'b0;
    evt_ready = 1'b1;
    key_pulse = 4'b0100;
    tick();
    key_pulse = '0;
    n_checks++;
    if (evt_valid !== 1'b0 || pending !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_relatch: got valid=%b pending=%b expected 0/0100", evt_valid, pending);
    end
    tick();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'd2 || evt_count !== 3'd1) begin
      n_fail++;
      $display("FAIL mid_event: got valid=%b code=%0d count=%0d expected 1/2/1", evt_valid, evt_code, evt_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_burst();
    test_round_robin();
    test_backpressure_drop();
    test_collision();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
